// File: rtl/fwd_sel_ctrl.sv
// Forwarding-select and load-use stall controller. Tracks destination metadata through EX/MEM/WB/RET.
// Sels are combinational from stage registers only; stall is combinational from ID and EX, one cycle per load-use.
module fwd_sel_ctrl #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          ex_flush,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel,
    output logic          stall,
    output logic          ex_valid
);

    logic          ex_valid_q, ex_valid_d;
    logic [AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [AW-1:0] ex_rs2_q, ex_rs2_d;
    logic [AW-1:0] ex_rd_q, ex_rd_d;
    logic          ex_regwrite_q, ex_regwrite_d;
    logic          ex_memread_q, ex_memread_d;

    logic          mem_valid_q, wb_valid_q, ret_valid_q;
    logic [AW-1:0] mem_rd_q, wb_rd_q, ret_rd_q;
    logic          mem_regwrite_q, wb_regwrite_q, ret_regwrite_q;

    function automatic logic writes(input logic v, input logic rw,
                                    input logic [AW-1:0] rd, input logic [AW-1:0] r);
        return v & rw & (rd == r) & (r != '0);
    endfunction

    function automatic logic [1:0] pick(input logic ex_v, input logic [AW-1:0] rs,
                                        input logic m_w, input logic w_w, input logic r_w);
        logic [1:0] s;
        s = 2'b00;
        if (ex_v && rs != '0) begin
            if (m_w)      s = 2'b01;
            else if (w_w) s = 2'b10;
            else if (r_w) s = 2'b11;
        end
        return s;
    endfunction

    always_comb begin
        stall = id_valid & ex_valid_q & ex_memread_q & ex_regwrite_q & (ex_rd_q != '0)
              & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2)) & ~ex_flush;
    end

    // Non-valid fields are still loaded on a bubble; the cleared valid bit masks them.
    always_comb begin
        ex_valid_d    = id_valid & ~ex_flush & ~stall;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_rd_d       = id_rd;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            ret_valid_q    <= 1'b0;
            ret_rd_q       <= '0;
            ret_regwrite_q <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= ex_valid_q;
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
            wb_valid_q     <= mem_valid_q;
            wb_rd_q        <= mem_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
            ret_valid_q    <= wb_valid_q;
            ret_rd_q       <= wb_rd_q;
            ret_regwrite_q <= wb_regwrite_q;
        end
    end

    // Newest producer wins: MEM, then WB, then RET.
    always_comb begin
        fwd_a_sel = pick(ex_valid_q, ex_rs1_q,
                         writes(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rs1_q),
                         writes(wb_valid_q,  wb_regwrite_q,  wb_rd_q,  ex_rs1_q),
                         writes(ret_valid_q, ret_regwrite_q, ret_rd_q, ex_rs1_q));
        fwd_b_sel = pick(ex_valid_q, ex_rs2_q,
                         writes(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rs2_q),
                         writes(wb_valid_q,  wb_regwrite_q,  wb_rd_q,  ex_rs2_q),
                         writes(ret_valid_q, ret_regwrite_q, ret_rd_q, ex_rs2_q));
    end

    assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl; inputs change 1ns after posedge, outputs sampled 1ns later.
module tb_fwd_sel_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic [4:0] id_rd = '0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       ex_flush = 1'b0;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, ex_valid;

    int passed = 0;
    int total  = 0;

    fwd_sel_ctrl #(.AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    // Advance to the next cycle and present one ID slot; returns with outputs settled.
    task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; ex_flush = fl;
        #1;
    endtask

    task automatic nop();
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) nop();
    endtask

    task automatic test_reset();
        #2;
        total++; if (fwd_a_sel !== 2'b00) $display("FAIL rst_init_a got %0d exp 0", fwd_a_sel); else passed++;
        total++; if (ex_valid !== 1'b0 || stall !== 1'b0) $display("FAIL rst_init_vs got ex_valid=%0d stall=%0d exp 0/0", ex_valid, stall); else passed++;
        @(posedge clk); #1; rst = 1'b0;
        drain();
        // Three writers in flight, the last a load whose rs1 hits the first.
        cyc(1'b1, 5'd0,  5'd0,  5'd11, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd0,  5'd0,  5'd12, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd11, 5'd0,  5'd13, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 5'd13, 5'd12, 5'd14, 1'b0, 1'b0, 1'b0);
        total++; if (fwd_a_sel !== 2'b10) $display("FAIL rst_pre_a got %0d exp 2", fwd_a_sel); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL rst_pre_stall got %0d exp 1", stall); else passed++;
        rst = 1'b1;
        #1;
        total++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) $display("FAIL rst_async_sel got %0d/%0d exp 0/0", fwd_a_sel, fwd_b_sel); else passed++;
        total++; if (stall !== 1'b0 || ex_valid !== 1'b0) $display("FAIL rst_async_vs got stall=%0d ex_valid=%0d exp 0/0", stall, ex_valid); else passed++;
        @(posedge clk); #3; rst = 1'b0;
        cyc(1'b1, 5'd11, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
        nop();
        total++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || ex_valid !== 1'b1) $display("FAIL rst_after got %0d/%0d v=%0d exp 0/0 v=1", fwd_a_sel, fwd_b_sel, ex_valid); else passed++;
        drain();
    endtask

    task automatic test_distance();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11; exp_sel[3] = 2'b00;
        for (int d = 1; d <= 4; d++) begin
            cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
            for (int k = 1; k < d; k++) nop();
            cyc(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            nop();
            total++;
            if (fwd_a_sel !== exp_sel[d-1] || ex_valid !== 1'b1)
                $display("FAIL dist%0d got sel=%0d v=%0d exp sel=%0d v=1", d, fwd_a_sel, ex_valid, exp_sel[d-1]);
            else passed++;
            drain();
        end
    endtask

    task automatic test_load_use();
        cyc(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b1) $display("FAIL lu_stall got %0d exp 1", stall); else passed++;
        cyc(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b0 || ex_valid !== 1'b0) $display("FAIL lu_bubble got stall=%0d v=%0d exp 0/0", stall, ex_valid); else passed++;
        nop();
        total++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10 || ex_valid !== 1'b1) $display("FAIL lu_fwd got %0d/%0d v=%0d exp 2/2 v=1", fwd_a_sel, fwd_b_sel, ex_valid); else passed++;
        drain();
        // rs2-only match also stalls
        cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 5'd3, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b1) $display("FAIL lu_rs2_stall got %0d exp 1", stall); else passed++;
        drain();
    endtask

    task automatic test_priority();
        cyc(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0);
        nop();
        total++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) $display("FAIL prio got %0d/%0d exp 1/0", fwd_a_sel, fwd_b_sel); else passed++;
        drain();
    endtask

    task automatic test_x0_bubble();
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b0);
        total++; if (stall !== 1'b0) $display("FAIL x0_stall got %0d exp 0", stall); else passed++;
        nop();
        total++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) $display("FAIL x0_sel got %0d/%0d exp 0/0", fwd_a_sel, fwd_b_sel); else passed++;
        drain();
        cyc(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        total++; if (ex_valid !== 1'b0) $display("FAIL flush_bubble got %0d exp 0", ex_valid); else passed++;
        nop();
        total++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || ex_valid !== 1'b1) $display("FAIL flush_sel got %0d/%0d v=%0d exp 0/0 v=1", fwd_a_sel, fwd_b_sel, ex_valid); else passed++;
        drain();
    endtask

    task automatic test_flush_vs_stall();
        cyc(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        total++; if (stall !== 1'b0) $display("FAIL fvs_stall got %0d exp 0", stall); else passed++;
        nop();
        total++; if (ex_valid !== 1'b0) $display("FAIL fvs_bubble got %0d exp 0", ex_valid); else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd2, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        total++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) $display("FAIL b2b_1 got %0d/%0d exp 1/0", fwd_a_sel, fwd_b_sel); else passed++;
        nop();
        total++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b10) $display("FAIL b2b_2 got %0d/%0d exp 1/2", fwd_a_sel, fwd_b_sel); else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_distance();
        test_load_use();
        test_priority();
        test_x0_bubble();
        test_flush_vs_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Sequential forwarding and hazard controller for the pipelined RISC-V core.
- Generates the 2-bit select codes that drive the ALU operand 4x1 muxes (fwd_a_sel, fwd_b_sel).
- Internally pipelines destination-register metadata through the EX, MEM, WB and RET stages. RET is the cycle after writeback.
- Detects load-use hazards, asserts a stall, and inserts an EX bubble.

Parameters:
- AW, 5, register-address width (32 architectural registers).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  instruction in ID is valid.
- id_rs1  input  AW  ID source register 1.
- id_rs2  input  AW  ID source register 2.
- id_rd  input  AW  ID destination register.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- ex_flush  input  1  branch/jump taken in EX; kill the instruction entering EX.
- fwd_a_sel  output  2  select for operand-A mux.
- fwd_b_sel  output  2  select for operand-B mux.
- stall  output  1  hold PC and IF/ID this cycle.
- ex_valid  output  1  EX slot holds a real (non-bubble) instruction.

Behaviour:
- Reset is asynchronous and active-high (rst):
  - All stage valid bits are 0 and all stored rs/rd fields are 0.
  - fwd_a_sel = fwd_b_sel = 2'b00, stall = 0, ex_valid = 0.
  - Reset asserted mid-operation discards all in-flight metadata immediately.
- Select encoding (fixed, shared with the datapath):
  - 00: register-file read data.
  - 01: MEM-stage ALU result.
  - 10: WB-stage writeback value.
  - 11: RET-stage value, i.e. the previous cycle's writeback, held by the datapath.
- Stage registers: EX holds {valid, rs1, rs2, rd, regwrite, memread}. MEM, WB and RET each hold {valid, rd, regwrite}.
- Per rising clk:
  - EX loads the ID fields with valid = id_valid, unless ex_flush = 1 or stall = 1. In either of those cases EX.valid <= 0 (bubble) and the other EX fields are don't-care.
  - MEM <= EX, WB <= MEM, RET <= WB, unconditionally. Stall never freezes EX and later stages.
- A stage "writes r" when stage.valid & stage.regwrite & stage.rd == r & r != 0.
- fwd_a_sel is combinational from registered state only; there is no path from the id_* inputs:
  - If !EX.valid or EX.rs1 == 0: 00.
  - Else if MEM writes EX.rs1: 01.
  - Else if WB writes EX.rs1: 10.
  - Else if RET writes EX.rs1: 11.
  - Else: 00.
  - Priority is newest producer first.
- fwd_b_sel follows the identical rule using EX.rs2.
- stall is combinational:
  - stall = id_valid & EX.valid & EX.memread & EX.regwrite & EX.rd != 0 & (EX.rd == id_rs1 | EX.rd == id_rs2) & !ex_flush.
  - ex_flush overrides stall: the younger ID instruction is being killed, so there is no stall.
- Latency: a producer one instruction ahead gives 01 and two ahead gives 10; both appear in the cycle the consumer occupies EX. Three ahead gives 11; four or more gives 00.
- Load-use: exactly one stall cycle. The bubble is in EX. On the next cycle the load is in WB and the consumer in EX sees 10. A load is therefore never forwarded via 01.
- Both operands matching the same producer: both sels carry the same code.
- x0 is never forwarded and never causes a stall.
- Bubbles (valid = 0) never match, regardless of their stale rd.

Test Plan:
1. Reset: assert rst asynchronously while three writers are in flight -> sel outputs 00, stall = 0, ex_valid = 0 immediately. After release, a consumer of their rd gets 00.
2. Forward distances:
   - Writer of x5 in ID at cycle t.
   - Consumer rs1 = x5 at t+1 -> fwd_a_sel = 01 at t+2.
   - Consumer at t+2 -> 10; at t+3 -> 11; at t+4 -> 00.
3. Load-use: lw x7 then add x8, x7, x7 -> stall = 1 for exactly one cycle and ex_valid = 0 the next cycle. Then fwd_a_sel = fwd_b_sel = 10 with the add in EX.
4. Priority: addi x3 then addi x3 then add x9, x3, x4 -> fwd_a_sel = 01 (newest), fwd_b_sel = 00.
5. x0 and bubbles:
   - Writer with rd = x0 followed by rs1 = x0 -> sel 00 and no stall.
   - Flushed writer of x6 followed by reader of x6 -> 00.
6. Flush vs. stall: lw x2 in EX, ID rs1 = x2, ex_flush = 1 in the same cycle -> stall = 0 and EX bubble next cycle.
